// File: rtl/shift_reg_pkg.sv
// Shared operation encoding for the multi-mode shift register.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_reg_fill_ctr.sv
// Counts valid stages: saturating increment on shift, jump to full on load.
module shift_reg_fill_ctr #(
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         inc,
  input  logic                         set_full,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
  output logic                         full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // full is kept as its own flop so it never hangs off a comparator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      full     <= 1'b0;
    end else if (clr) begin
      fill_cnt <= '0;
      full     <= 1'b0;
    end else if (set_full) begin
      fill_cnt <= CW'(DEPTH);
      full     <= 1'b1;
    end else if (inc && !full) begin
      fill_cnt <= fill_cnt + CW'(1);
      full     <= (fill_cnt == CW'(DEPTH - 1));
    end
  end

endmodule

// File: rtl/shift_reg_mm.sv
// Multi-mode shift register: hold, serial shift, parallel load, rotate.
module shift_reg_mm
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic [MODE_W-1:0]           mode,
  input  logic [WIDTH-1:0]            din,
  input  logic [DEPTH*WIDTH-1:0]      load_data,
  output logic [WIDTH-1:0]            dout,
  output logic [DEPTH*WIDTH-1:0]      q_all,
  output logic [$clog2(DEPTH+1)-1:0]  fill_cnt,
  output logic                        full
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("shift_reg_mm: WIDTH out of range");
  end
  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("shift_reg_mm: DEPTH out of range");
  end

  mode_e                   op;
  logic                    inc;
  logic                    set_full;
  logic [DEPTH*WIDTH-1:0]  stage_q;

  assign op       = mode_e'(mode);
  assign inc      = en && (op == MODE_SHIFT);
  assign set_full = en && (op == MODE_LOAD);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] q;

    // stage 0 is the only one whose shift source depends on the mode
    if (k == 0) begin : g_head
      assign src = (op == MODE_ROTATE) ? stage_q[(DEPTH-1)*WIDTH +: WIDTH] : din;
    end else begin : g_body
      assign src = stage_q[(k-1)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (clr) begin
        q <= '0;
      end else if (en) begin
        case (op)
          MODE_SHIFT, MODE_ROTATE: q <= src;
          MODE_LOAD:               q <= load_data[k*WIDTH +: WIDTH];
          default:                 q <= q;
        endcase
      end
    end

    assign stage_q[k*WIDTH +: WIDTH] = q;
  end

  shift_reg_fill_ctr #(
    .DEPTH (DEPTH)
  ) u_fill_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (inc),
    .set_full (set_full),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

  assign q_all = stage_q;
  assign dout  = stage_q[(DEPTH-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_shift_reg_mm.sv
// Scoreboard bench for shift_reg_mm (WIDTH=8, DEPTH=4) against a queue-based model.
module tb_shift_reg_mm;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  typedef struct {
    logic [D*W-1:0] q_all;
    logic [W-1:0]   dout;
    logic [CW-1:0]  fill;
    logic           full;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr;
  logic           en;
  logic [1:0]     mode;
  logic [W-1:0]   din;
  logic [D*W-1:0] load_data;
  logic [W-1:0]   dout;
  logic [D*W-1:0] q_all;
  logic [CW-1:0]  fill_cnt;
  logic           full;

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [W-1:0] mq[$];
  int           mfill;

  shift_reg_mm #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .load_data (load_data),
    .dout      (dout),
    .q_all     (q_all),
    .fill_cnt  (fill_cnt),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int k = 0; k < D; k++) mq.push_back('0);
    mfill = 0;
  endtask

  task automatic push_expect();
    exp_t e;
    e.q_all = '0;
    for (int k = 0; k < D; k++) e.q_all[k*W +: W] = mq[k];
    e.dout = mq[D-1];
    e.fill = CW'(mfill);
    e.full = (mfill == D);
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive one cycle of inputs and predict the next edge.
  task automatic step(input logic c, input logic e, input logic [1:0] m,
                      input logic [W-1:0] d, input logic [D*W-1:0] ld);
    logic [W-1:0] t;
    clr = c; en = e; mode = m; din = d; load_data = ld;
    if (c) begin
      model_clear();
    end else if (e) begin
      case (m)
        2'b01: begin
          mq.push_front(d);
          t = mq.pop_back();
          mfill = (mfill + 1 > D) ? D : mfill + 1;
        end
        2'b10: begin
          for (int k = 0; k < D; k++) mq[k] = ld[k*W +: W];
          mfill = D;
        end
        2'b11: begin
          t = mq.pop_back();
          mq.push_front(t);
        end
        default: ;
      endcase
    end
    push_expect();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed in the high phase, between two rising edges.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    model_clear();
    push_expect();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every rising edge (and every reset assertion) presents a new output state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q_all", 64'(q_all), 64'(e.q_all));
        check("dout", 64'(dout), 64'(e.dout));
        check("fill_cnt", 64'(fill_cnt), 64'(e.fill));
        check("full", 64'(full), 64'(e.full));
      end
    end
  end

  initial begin
    logic [D*W-1:0] img;
    logic [W-1:0]   w;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00; din = '0; load_data = '0;
    model_clear();
    @(negedge clk);
    push_expect();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturating shift: 0xA0..0xA5
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'b01, W'(8'hA0 + i), '0);

    // Load then rotate once, then three more times
    img = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1'b0, 1'b1, 2'b10, 8'hFF, img);
    step(1'b0, 1'b1, 2'b11, 8'hEE, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 8'hDD, '0);
    step(1'b0, 1'b1, 2'b00, 8'hCC, '0);

    // Disabled shift, then clear while disabled
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b01, W'(8'h70 + i), '0);
    step(1'b1, 1'b0, 2'b01, 8'h99, img);

    // Shift burst with hold gaps, interrupted by an async reset
    step(1'b0, 1'b1, 2'b01, 8'h31, '0);
    step(1'b0, 1'b1, 2'b00, 8'h00, '0);
    step(1'b0, 1'b1, 2'b01, 8'h32, '0);
    step(1'b0, 1'b1, 2'b01, 8'h33, '0);
    reset_pulse();
    step(1'b0, 1'b1, 2'b01, 8'h5A, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      w = W'($urandom);
      img = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 2) reset_pulse();
      step(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 80),
           2'($urandom_range(0, 3)), w, img);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_mm.md
SHIFT_REG_MM -- requirements
Module: shift_reg_mm

Interface
REQ-001 Parameter WIDTH, default 1: bits per stage; legal range is 1..64.
REQ-002 Parameter DEPTH, default 3: number of stages; legal range is 2..64.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port clr, input, 1 bit: synchronous clear of all stages and of the fill count.
REQ-006 Port en, input, 1 bit: operation enable; when en=0 the block SHALL behave as HOLD.
REQ-007 Port mode, input, 2 bits: operation select; 00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE.
REQ-008 Port din, input, WIDTH bits: serial input word, written into stage 0 on SHIFT.
REQ-009 Port load_data, input, DEPTH*WIDTH bits: parallel load image; slice [WIDTH*(k+1)-1 : WIDTH*k] loads stage k.
REQ-010 Port dout, output, WIDTH bits: contents of stage DEPTH-1, registered.
REQ-011 Port q_all, output, DEPTH*WIDTH bits: all stages, with stage k in slice k.
REQ-012 Port fill_cnt, output, $clog2(DEPTH+1) bits: number of valid stages.
REQ-013 Port full, output, 1 bit: asserted when fill_cnt == DEPTH.

Function
REQ-014 Priority per rising edge SHALL be: clr first, then en=0, then the operation selected by mode.
REQ-015 On clr=1, all stages and fill_cnt SHALL become 0 on that edge, regardless of en and mode.
REQ-016 In HOLD, or when en=0, stages and fill_cnt SHALL be unchanged.
REQ-017 In SHIFT, stage 0 SHALL take din and stage k SHALL take stage k-1 for k=1..DEPTH-1; the old stage DEPTH-1 is discarded.
REQ-018 In SHIFT, fill_cnt SHALL increment by 1, saturating at DEPTH.
REQ-019 Latency: a word on din SHALL appear on dout exactly DEPTH enabled SHIFT edges later; HOLD cycles in between SHALL add no loss and no reordering.
REQ-020 In LOAD, every stage SHALL take its load_data slice, and fill_cnt SHALL become DEPTH.
REQ-021 In ROTATE, stage 0 SHALL take the old stage DEPTH-1, and stage k SHALL take stage k-1 for k=1..DEPTH-1.
REQ-022 In ROTATE, fill_cnt SHALL be unchanged, and din SHALL be ignored.
REQ-023 DEPTH consecutive ROTATE edges SHALL restore the original contents.
REQ-024 dout, q_all, fill_cnt and full SHALL be driven directly from registers, with no combinational path from any input.
REQ-025 WIDTH=1, DEPTH=3, mode=SHIFT, en=1 SHALL reproduce the behaviour of a plain 3-stage serial shift register.

Reset
REQ-026 rst_n low SHALL asynchronously force all stages, dout, q_all and fill_cnt to 0, and full to 0.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no partial update retained.
REQ-028 The first operation after reset SHALL take effect on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package shift_reg_pkg SHALL hold the mode enum and the constants MODE_HOLD, MODE_SHIFT, MODE_LOAD and MODE_ROTATE.
REQ-030 The fill counter SHALL be a sub-module named shift_reg_fill_ctr, parametrised by DEPTH, with inputs inc, set_full and clr.
REQ-031 The stage array SHALL be generated with a generate loop over DEPTH; no hand-unrolled stages.

Verification
REQ-032 Defaults (WIDTH=1, DEPTH=3): SHIFT din sequence 1,0,1 -> dout = 1 after the 3rd SHIFT edge; fill_cnt = 3; full = 1.
REQ-033 WIDTH=8, DEPTH=4: LOAD stages 0..3 = 0x11, 0x22, 0x33, 0x44 -> dout = 0x44.
  - Then 1 ROTATE -> stage 0 = 0x44, dout = 0x33.
  - Then 3 more ROTATE -> contents are the original image again.
REQ-034 WIDTH=8, DEPTH=4: 6 SHIFT edges with din = 0xA0..0xA5 -> fill_cnt saturates at 4; dout = 0xA2; q_all stages 0..3 = 0xA5, 0xA4, 0xA3, 0xA2.
REQ-035 en=0 with mode=SHIFT for 5 cycles -> no change to q_all or fill_cnt; clr=1 with en=0 -> all zero, fill_cnt = 0, full = 0.
REQ-036 rst_n pulsed low between clock edges during a SHIFT burst -> outputs go 0 immediately, without waiting for a clock edge; a subsequent SHIFT of 0x5A -> stage 0 = 0x5A, fill_cnt = 1.
